// File: rtl/memory.sv
// Memory-access stage: issues single-beat data-bus requests for loads/stores,
// stalls upstream until the response, and registers the aligned result for writeback.
package memory_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic        valid;
    logic [31:0] raw_instr;
    logic [15:0] ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rd2;
  } excute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic        valid;
    logic [31:0] raw_instr;
    logic [15:0] ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] addr;
    logic        misalign;
  } memory_data_t;
endpackage

module memory
  import memory_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  output memory_data_t dataM,
  output logic         stopm,
  output logic         dreq_valid,
  output logic [63:0]  dreq_addr,
  output logic [2:0]   dreq_size,
  output logic [7:0]   dreq_strobe,
  output logic [63:0]  dreq_data,
  input  logic         dresp_data_ok,
  input  logic [63:0]  dresp_data
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]   state_q, state_d;
  memory_data_t dataM_q, dataM_d;

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [2:0]   a;
  logic         is_load, is_store, memop, mis, access;
  logic [63:0]  shifted, load_val;

  assign opcode   = dataE.raw_instr[6:0];
  assign funct3   = dataE.raw_instr[14:12];
  assign a        = dataE.result[2:0];
  assign is_load  = dataE.valid && (opcode == 7'b0000011);
  assign is_store = dataE.valid && (opcode == 7'b0100011);
  assign memop    = is_load | is_store;

  always_comb begin
    mis = 1'b0;
    case (funct3[1:0])
      2'd0: mis = 1'b0;
      2'd1: mis = a[0];
      2'd2: mis = |a[1:0];
      2'd3: mis = |a;
      default: mis = 1'b0;
    endcase
    mis = mis & memop;
  end

  assign access = memop & ~mis;

  // The request is derived from dataE in both states; execute holds it while stalled.
  // Gating by reset drops the request asynchronously when reset hits mid-WAIT.
  always_comb begin
    dreq_valid = 1'b0;
    case (state_q)
      IDLE:    dreq_valid = access;
      WAIT:    dreq_valid = access;
      default: dreq_valid = 1'b0;
    endcase
    dreq_valid = dreq_valid & ~reset;
  end

  assign stopm     = dreq_valid & ~dresp_data_ok;
  assign dreq_addr = dataE.result;
  assign dreq_size = {1'b0, funct3[1:0]};
  assign dreq_data = dataE.rd2 << {a, 3'b000};

  always_comb begin
    dreq_strobe = 8'h00;
    if (is_store) begin
      case (funct3[1:0])
        2'd0:    dreq_strobe = 8'h01 << a;
        2'd1:    dreq_strobe = 8'h03 << a;
        2'd2:    dreq_strobe = 8'h0F << a;
        default: dreq_strobe = 8'hFF;
      endcase
    end
  end

  assign shifted = dresp_data >> {a, 3'b000};

  always_comb begin
    load_val = shifted;
    case (funct3[1:0])
      2'd0: load_val = {{56{~funct3[2] & shifted[7]}},  shifted[7:0]};
      2'd1: load_val = {{48{~funct3[2] & shifted[15]}}, shifted[15:0]};
      2'd2: load_val = {{32{~funct3[2] & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !dresp_data_ok) state_d = WAIT;
      WAIT:    if (dresp_data_ok || !access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dataM_d = dataM_q;
    if (stopm) begin
      dataM_d.valid = 1'b0;
    end else begin
      dataM_d.pc        = dataE.pc;
      dataM_d.valid     = dataE.valid;
      dataM_d.raw_instr = dataE.raw_instr;
      dataM_d.ctl       = dataE.ctl;
      dataM_d.dst       = dataE.dst;
      dataM_d.result    = (is_load && !mis) ? load_val : dataE.result;
      dataM_d.addr      = dataE.result;
      dataM_d.misalign  = mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dataM_q <= '0;
    end else begin
      state_q <= state_d;
      dataM_q <= dataM_d;
    end
  end

  assign dataM = dataM_q;
endmodule

// File: tb/tb_memory.sv
// Randomized and directed bench for the memory stage against a byte-level
// reference model of alignment, strobes and load extension.
module tb_memory;
  import memory_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  excute_data_t dataE;
  memory_data_t dataM;
  logic         stopm, dreq_valid;
  logic [63:0]  dreq_addr, dreq_data, dresp_data;
  logic [2:0]   dreq_size;
  logic [7:0]   dreq_strobe;
  logic         dresp_data_ok;

  int vectors = 0;
  int miscompares = 0;

  memory dut (
    .clk(clk), .reset(reset), .dataE(dataE), .dataM(dataM), .stopm(stopm),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = 32'h0;
    r[6:0]   = op;
    r[14:12] = f3;
    r[11:7]  = 5'd3;
    return r;
  endfunction

  // Gather the addressed bytes one at a time, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [2:0] f3);
    int n, off;
    logic [63:0] v;
    n   = 1 << f3[1:0];
    off = int'(addr % 8);
    v   = 64'h0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  // One instruction presented from posedge+1 until it retires; responds after 'delay' cycles.
  task automatic test_mem_op(input string name, input logic v, input logic [31:0] instr,
                             input logic [63:0] addr, input logic [63:0] rd2,
                             input logic [63:0] rdata, input int delay_in);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          n, dly;
    logic        is_ld, is_st, mis, req;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data, exp_res, pc;
    op    = instr[6:0];
    f3    = instr[14:12];
    n     = 1 << f3[1:0];
    is_ld = v && op == OP_LOAD;
    is_st = v && op == OP_STORE;
    mis   = (is_ld || is_st) && (addr % n) != 0;
    req   = (is_ld || is_st) && !mis;
    dly   = req ? delay_in : 0;
    exp_strb = 8'h00;
    if (is_st) for (int i = 0; i < n; i++) exp_strb[int'(addr % 8) + i] = 1'b1;
    exp_data = rd2 << (8 * (addr % 8));
    exp_res  = (is_ld && !mis) ? ref_load(rdata, addr, f3) : addr;
    pc       = {32'h0, $urandom};

    dataE.pc = pc; dataE.valid = v; dataE.raw_instr = instr; dataE.ctl = 16'h00A5;
    dataE.dst = 5'd3; dataE.result = addr; dataE.rd2 = rd2;
    dresp_data = rdata;
    for (int k = 0; k <= dly; k++) begin
      dresp_data_ok = (k == dly);
      @(negedge clk);
      vectors++;
      if (dreq_valid !== req) begin
        miscompares++;
        $display("FAIL %s dreq_valid cyc%0d got %b exp %b", name, k, dreq_valid, req);
      end
      vectors++;
      if (stopm !== (req && k < dly)) begin
        miscompares++;
        $display("FAIL %s stopm cyc%0d got %b exp %b", name, k, stopm, req && k < dly);
      end
      if (req) begin
        vectors++;
        if (dreq_addr !== addr || dreq_size !== {1'b0, f3[1:0]} ||
            dreq_strobe !== exp_strb || dreq_data !== exp_data) begin
          miscompares++;
          $display("FAIL %s req_fields cyc%0d got a=%h s=%0d st=%h d=%h exp a=%h s=%0d st=%h d=%h",
                   name, k, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                   addr, f3[1:0], exp_strb, exp_data);
        end
      end
      @(posedge clk); #1;
      vectors++;
      if (dataM.valid !== ((k == dly) ? v : 1'b0)) begin
        miscompares++;
        $display("FAIL %s dataM.valid cyc%0d got %b exp %b", name, k, dataM.valid,
                 (k == dly) ? v : 1'b0);
      end
    end
    vectors++;
    if (dataM.result !== exp_res || dataM.misalign !== mis || dataM.addr !== addr ||
        dataM.pc !== pc || dataM.raw_instr !== instr || dataM.dst !== 5'd3) begin
      miscompares++;
      $display("FAIL %s dataM got res=%h mis=%b addr=%h pc=%h exp res=%h mis=%b addr=%h pc=%h",
               name, dataM.result, dataM.misalign, dataM.addr, dataM.pc, exp_res, mis, addr, pc);
    end
    dresp_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (dataM !== '0 || dreq_valid !== 1'b0 || stopm !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got valid=%b dreq=%b stopm=%b exp all 0",
               dataM.valid, dreq_valid, stopm);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    test_mem_op("lb",  1, mk_instr(OP_LOAD, 3'd0), 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0);
    test_mem_op("lbu", 1, mk_instr(OP_LOAD, 3'd4), 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0);
    test_mem_op("sh",  1, mk_instr(OP_STORE, 3'd1), 64'h2006, 64'h1234, 64'h0, 0);
    test_mem_op("ld_delay3", 1, mk_instr(OP_LOAD, 3'd3), 64'h3000, 64'h0,
                64'hDEAD_BEEF_0123_4567, 3);
    test_mem_op("lw_misalign", 1, mk_instr(OP_LOAD, 3'd2), 64'h4002, 64'h0, 64'hFFFF_FFFF, 2);
    test_mem_op("invalid_ld", 0, mk_instr(OP_LOAD, 3'd3), 64'h5000, 64'h0, 64'h1, 2);
  endtask

  task automatic test_back_to_back();
    test_mem_op("b2b_add", 1, mk_instr(OP_ALU, 3'd0),   64'h0000_0000_0000_0777, 64'h0, 64'h0, 0);
    test_mem_op("b2b_sd",  1, mk_instr(OP_STORE, 3'd3), 64'h6008, 64'hCAFE_F00D_1234_5678, 64'h0, 0);
    test_mem_op("b2b_ld",  1, mk_instr(OP_LOAD, 3'd3),  64'h6008, 64'h0, 64'h1111_2222_3333_4444, 0);
  endtask

  task automatic test_reset_wait();
    dataE.pc = 64'h100; dataE.valid = 1'b1; dataE.raw_instr = mk_instr(OP_LOAD, 3'd3);
    dataE.ctl = 16'h0; dataE.dst = 5'd3; dataE.result = 64'h7000; dataE.rd2 = 64'h0;
    dresp_data_ok = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (stopm !== 1'b1 || dreq_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wait_pre got stopm=%b dreq=%b exp 1 1", stopm, dreq_valid);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (dreq_valid !== 1'b0 || stopm !== 1'b0 || dataM.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait got dreq=%b stopm=%b valid=%b exp 0 0 0",
               dreq_valid, stopm, dataM.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    // A late response arrives alongside a plain ALU op and must be ignored.
    test_mem_op("post_rst_add", 1, mk_instr(OP_ALU, 3'd0), 64'h42, 64'h0, 64'hFFFF, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [63:0] addr;
      int sel;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? OP_LOAD : (sel < 8) ? OP_STORE : OP_ALU;
      f3  = 3'($urandom_range(0, 7));
      if (op == OP_STORE) f3[2] = 1'b0;
      if (op == OP_LOAD && f3 == 3'd7) f3 = 3'd3;
      addr = {32'h0, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 1);
      test_mem_op("rand", ($urandom_range(0, 7) != 0), mk_instr(op, f3), addr,
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
  endtask

  initial begin
    reset = 1'b1;
    dataE = '0;
    dresp_data_ok = 1'b0;
    dresp_data = 64'h0;
    #12;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
